// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file with a two-state trap sequencer.
// Synchronises the timer/external IRQs and redirects the PC on trap entry and on mret.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] pc_mw,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic        is_mret,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [3:0] CODE_TIMER = 4'd7;
  localparam logic [3:0] CODE_EXT   = 4'd11;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] timer_sync, ext_sync;

  logic        mstatus_mie, mstatus_mpie;
  logic        mie_mtie, mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;

  logic        mip_mtip, mip_meip;
  logic        pend;
  logic        in_idle;
  logic        trap_now;
  logic        mret_now;
  logic        wr_en;
  logic [3:0]  trap_code;
  logic [31:0] vec_base;
  logic [31:0] trap_target;

  // Plain flop chains; the last stage is what mip reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_sync <= '0;
      ext_sync   <= '0;
    end else begin
      timer_sync <= {timer_sync[SYNC_STAGES-2:0], timer_irq};
      ext_sync   <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
    end
  end

  assign mip_mtip = timer_sync[SYNC_STAGES-1];
  assign mip_meip = ext_sync[SYNC_STAGES-1];

  assign pend = mstatus_mie && ((mip_meip && mie_meie) || (mip_mtip && mie_mtie));

  assign in_idle  = (state == IDLE);
  assign trap_now = in_idle && pend && inst_valid && !is_mret;
  assign mret_now = in_idle && is_mret && inst_valid;

  // A trapped instruction is flushed, so its CSR write must not land.
  assign wr_en = csr_wr && inst_valid && in_idle && !trap_now;

  assign trap_code   = (mip_meip && mie_meie) ? CODE_EXT : CODE_TIMER;
  assign vec_base    = {mtvec[31:2], 2'b00};
  assign trap_target = (mtvec[1:0] == 2'b01) ? (vec_base + {26'd0, trap_code, 2'b00})
                                              : vec_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    epc_taken  = 1'b0;
    epc        = 32'd0;
    case (state)
      IDLE: begin
        if (trap_now) begin
          epc_taken  = 1'b1;
          epc        = trap_target;
          state_next = HOLD;
        end else if (mret_now) begin
          epc_taken  = 1'b1;
          epc        = mepc;
          state_next = HOLD;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Trap entry and mret own mstatus in their cycle; software writes fill in otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
    end else if (trap_now) begin
      mepc         <= pc_mw & ~32'h3;
      mcause       <= {1'b1, 27'd0, trap_code};
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          ADDR_MIE: begin
            mie_mtie <= csr_wdata[7];
            mie_meie <= csr_wdata[11];
          end
          ADDR_MTVEC:  mtvec  <= csr_wdata;
          ADDR_MEPC:   mepc   <= csr_wdata & ~32'h3;
          ADDR_MCAUSE: mcause <= csr_wdata;
          default: ;
        endcase
      end
      if (mret_now) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    if (csr_rd) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          csr_rdata[3] = mstatus_mie;
          csr_rdata[7] = mstatus_mpie;
        end
        ADDR_MIE: begin
          csr_rdata[7]  = mie_mtie;
          csr_rdata[11] = mie_meie;
        end
        ADDR_MTVEC:  csr_rdata = mtvec;
        ADDR_MEPC:   csr_rdata = mepc;
        ADDR_MCAUSE: csr_rdata = mcause;
        ADDR_MIP: begin
          csr_rdata[7]  = mip_mtip;
          csr_rdata[11] = mip_meip;
        end
        default: csr_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: CSR access, trap entry, vectoring, mret ordering, reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_csr_trap_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0A00;
  localparam int          SYNC      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] pc_mw;
  logic        csr_rd;
  logic        csr_wr;
  logic        is_mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc;

  int total = 0;
  int bad   = 0;

  csr_trap_ctrl #(
    .MTVEC_RESET(MTVEC_RST),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst_valid(inst_valid),
    .pc_mw(pc_mw),
    .csr_rd(csr_rd),
    .csr_wr(csr_wr),
    .is_mret(is_mret),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .timer_irq(timer_irq),
    .ext_irq(ext_irq),
    .csr_rdata(csr_rdata),
    .epc_taken(epc_taken),
    .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    inst_valid = 1'b1;
    csr_wr     = 1'b1;
    csr_addr   = a;
    csr_wdata  = d;
    @(posedge clk);
    #1;
    csr_wr     = 1'b0;
    inst_valid = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_rd   = 1'b1;
    csr_addr = a;
    #1;
    d      = csr_rdata;
    csr_rd = 1'b0;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0;
    inst_valid = 1'b0; pc_mw = '0; csr_rd = 1'b0; csr_wr = 1'b0; is_mret = 1'b0;
    csr_addr = '0; csr_wdata = '0; timer_irq = 1'b0; ext_irq = 1'b0;
    repeat (2) @(negedge clk);
    csr_rd = 1'b1; csr_addr = 12'h305;
    #1;
    total++; if (csr_rdata !== MTVEC_RST) begin bad++; $display("FAIL reset_mtvec got=%h want=%h", csr_rdata, MTVEC_RST); end
    total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL reset_epc_taken got=%b want=0", epc_taken); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h want=0", epc); end
    csr_addr = 12'h300;
    #1;
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL reset_mstatus got=%h want=0", csr_rdata); end
    csr_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    csr_read(12'h300, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_mstatus got=%h want=0", d); end
  endtask

  task automatic test_csr_rw;
    logic [31:0] d;
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h304, 32'h0000_0880);
    csr_write(12'h300, 32'h0000_0008);
    csr_read(12'h305, d);
    total++; if (d !== 32'h100) begin bad++; $display("FAIL rw_mtvec got=%h want=100", d); end
    csr_read(12'h304, d);
    total++; if (d !== 32'h880) begin bad++; $display("FAIL rw_mie got=%h want=880", d); end
    csr_read(12'h300, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL rw_mstatus got=%h want=8", d); end
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read(12'h344, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mip_readonly got=%h want=0", d); end
    csr_write(12'h341, 32'h0000_0123);
    csr_read(12'h341, d);
    total++; if (d !== 32'h120) begin bad++; $display("FAIL mepc_align got=%h want=120", d); end
    csr_read(12'h340, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unimpl_read got=%h want=0", d); end
    @(negedge clk);
    csr_rd = 1'b0; csr_addr = 12'h305;
    #1;
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL no_rd_zero got=%h want=0", csr_rdata); end
    // write and read the same CSR in one cycle: read sees the old value
    @(negedge clk);
    inst_valid = 1'b1; csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h0000_1234;
    #1;
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL same_cycle_old got=%h want=0", csr_rdata); end
    @(posedge clk);
    #1;
    inst_valid = 1'b0; csr_wr = 1'b0; csr_rd = 1'b0;
    csr_read(12'h342, d);
    total++; if (d !== 32'h1234) begin bad++; $display("FAIL mcause_write got=%h want=1234", d); end
    csr_write(12'h300, 32'hFFFF_FFFF);
    csr_read(12'h300, d);
    total++; if (d !== 32'h88) begin bad++; $display("FAIL mstatus_mask got=%h want=88", d); end
    csr_write(12'h300, 32'h0000_0008);
  endtask

  task automatic test_timer_trap;
    logic [31:0] d;
    int lat;
    @(negedge clk);
    timer_irq = 1'b1; pc_mw = 32'h40; inst_valid = 1'b1;
    lat = 0;
    while (lat < 8) begin
      #1;
      if (epc_taken === 1'b1) break;
      @(negedge clk);
      lat++;
    end
    total++; if (lat != SYNC) begin bad++; $display("FAIL timer_latency got=%0d want=%0d", lat, SYNC); end
    total++; if (epc !== 32'h100) begin bad++; $display("FAIL timer_epc got=%h want=100", epc); end
    $display("timer trap latency=%0d epc=%h", lat, epc);
    @(posedge clk);
    #1;
    total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL hold_no_redirect got=%b want=0", epc_taken); end
    inst_valid = 1'b0;
    timer_irq  = 1'b0;
    csr_read(12'h341, d);
    total++; if (d !== 32'h40) begin bad++; $display("FAIL timer_mepc got=%h want=40", d); end
    csr_read(12'h342, d);
    total++; if (d !== 32'h8000_0007) begin bad++; $display("FAIL timer_mcause got=%h want=80000007", d); end
    csr_read(12'h300, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL timer_mstatus got=%h want=80", d); end
  endtask

  task automatic test_mret;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    is_mret = 1'b1; inst_valid = 1'b1;
    #1;
    total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL mret_taken got=%b want=1", epc_taken); end
    total++; if (epc !== 32'h40) begin bad++; $display("FAIL mret_epc got=%h want=40", epc); end
    $display("mret epc_taken=%b epc=%h", epc_taken, epc);
    @(posedge clk);
    #1;
    is_mret = 1'b0; inst_valid = 1'b0;
    csr_read(12'h300, d);
    total++; if (d !== 32'h88) begin bad++; $display("FAIL mret_mstatus got=%h want=88", d); end
  endtask

  task automatic test_vectored;
    logic [31:0] d;
    csr_write(12'h305, 32'h0000_0101);
    @(negedge clk);
    timer_irq = 1'b1; ext_irq = 1'b1; inst_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL no_valid_no_trap got=%b want=0", epc_taken); end
    @(negedge clk);
    pc_mw = 32'h80; inst_valid = 1'b1;
    csr_wr = 1'b1; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEEC;
    #1;
    total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL vec_taken got=%b want=1", epc_taken); end
    total++; if (epc !== 32'h12C) begin bad++; $display("FAIL vec_epc got=%h want=12c", epc); end
    $display("vectored trap epc=%h", epc);
    @(posedge clk);
    #1;
    csr_wr = 1'b0; inst_valid = 1'b0;
    csr_read(12'h342, d);
    total++; if (d !== 32'h8000_000B) begin bad++; $display("FAIL vec_mcause got=%h want=8000000b", d); end
    csr_read(12'h341, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL wr_suppress_mepc got=%h want=80", d); end
    csr_read(12'h300, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL vec_mstatus got=%h want=80", d); end
  endtask

  task automatic test_mret_vs_pend;
    logic [31:0] d;
    // both IRQs still high: enabling MIE makes the interrupt pending
    csr_write(12'h300, 32'h0000_0088);
    @(negedge clk);
    is_mret = 1'b1; inst_valid = 1'b1;
    #1;
    total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL mret_first_taken got=%b want=1", epc_taken); end
    total++; if (epc !== 32'h80) begin bad++; $display("FAIL mret_first_epc got=%h want=80", epc); end
    @(posedge clk);
    #1;
    is_mret = 1'b0;
    csr_wr = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0;
    #1;
    total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL hold_irq_blocked got=%b want=0", epc_taken); end
    @(posedge clk);
    #1;
    csr_wr = 1'b0;
    #1;
    total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL after_hold_trap got=%b want=1", epc_taken); end
    total++; if (epc !== 32'h12C) begin bad++; $display("FAIL after_hold_epc got=%h want=12c", epc); end
    $display("post-hold trap epc_taken=%b epc=%h", epc_taken, epc);
    @(posedge clk);
    #1;
    inst_valid = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;
    csr_read(12'h300, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL retrap_mstatus got=%h want=80", d); end
  endtask

  task automatic test_async_reset;
    timer_irq = 1'b1;
    repeat (3) @(negedge clk);
    csr_write(12'h300, 32'h0000_0008);
    @(negedge clk);
    pc_mw = 32'hC0; inst_valid = 1'b1;
    #1;
    total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL pre_reset_trap got=%b want=1", epc_taken); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL midhold_rst_taken got=%b want=0", epc_taken); end
    csr_rd = 1'b1; csr_addr = 12'h305;
    #1;
    total++; if (csr_rdata !== MTVEC_RST) begin bad++; $display("FAIL midhold_rst_mtvec got=%h want=%h", csr_rdata, MTVEC_RST); end
    csr_addr = 12'h341;
    #1;
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL midhold_rst_mepc got=%h want=0", csr_rdata); end
    csr_addr = 12'h344;
    #1;
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL midhold_rst_mip got=%h want=0", csr_rdata); end
    csr_addr = 12'h300;
    #1;
    total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL midhold_rst_mstatus got=%h want=0", csr_rdata); end
    $display("async reset mid-hold checked");
    csr_rd = 1'b0; inst_valid = 1'b0; timer_irq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_csr_rw();
    test_timer_trap();
    test_mret();
    test_vectored();
    test_mret_vs_pend();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
